// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// rtl/bcd_stopwatch_ctrl_pkg.sv - shared state encoding and BCD constants for the stopwatch controller
package bcd_stopwatch_ctrl_pkg;

    localparam int NIBBLE_W = 4;
    localparam logic [NIBBLE_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } sw_state_e;

    // Non-decimal nibbles from the preset bus collapse to zero rather than counting through A..F.
    function automatic logic [NIBBLE_W-1:0] bcd_sanitise(input logic [NIBBLE_W-1:0] nib);
        return (nib > BCD_MAX) ? '0 : nib;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// rtl/bcd_stopwatch_ctrl_if.sv - control/display bundle of the stopwatch controller; lap exists only with LAP_HOLD_EN
interface bcd_stopwatch_ctrl_if
    import bcd_stopwatch_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic                     start_stop;
    logic                     clear;
    logic                     load_en;
    logic [NIBBLE_W*DIGITS-1:0] load_value;
    logic [NIBBLE_W*DIGITS-1:0] bcd_out;
    logic                     running;
    logic                     tick;
    logic                     overflow;
`ifdef LAP_HOLD_EN
    logic                     lap;

    modport master (
        output start_stop, clear, load_en, load_value, lap,
        input  bcd_out, running, tick, overflow
    );
    modport slave (
        input  start_stop, clear, load_en, load_value, lap,
        output bcd_out, running, tick, overflow
    );
`else
    modport master (
        output start_stop, clear, load_en, load_value,
        input  bcd_out, running, tick, overflow
    );
    modport slave (
        input  start_stop, clear, load_en, load_value,
        output bcd_out, running, tick, overflow
    );
`endif
endinterface

// File: rtl/bcd_stopwatch_ctrl_bcd_digit_cell.sv
// rtl/bcd_stopwatch_ctrl_bcd_digit_cell.sv - one mod-10 digit with clear, sanitised load, enable and carry-out
module bcd_digit_cell
    import bcd_stopwatch_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                load,
    input  logic [NIBBLE_W-1:0] load_digit,
    input  logic                enable,
    output logic [NIBBLE_W-1:0] digit,
    output logic                carry_out
);
    logic [NIBBLE_W-1:0] digit_q;
    logic [NIBBLE_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clear) begin
            digit_d = '0;
        end else if (load) begin
            digit_d = bcd_sanitise(load_digit);
        end else if (enable) begin
            digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = (digit_q == BCD_MAX);
endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// rtl/bcd_stopwatch_ctrl.sv - run/pause/clear sequencer, prescaler and digit carry chain; LAP_HOLD_EN adds a lap freeze
module bcd_stopwatch_ctrl
    import bcd_stopwatch_ctrl_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int TICK_DIV    = 500000,
    parameter int STOP_AT_MAX = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    bcd_stopwatch_ctrl_if.slave  bus
);
    localparam int W  = NIBBLE_W * DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sw_state_e        state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             running_q;

    logic [W-1:0]      digits;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] digit_en;
    logic              carry_acc;
    logic              tick;
    logic              all_nine;
    logic              saturate;
    logic              load_ok;

    assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign all_nine = &carry;
    assign saturate = (STOP_AT_MAX != 0) && all_nine;
    assign load_ok  = bus.load_en && !bus.clear
                   && ((state_q == ST_IDLE) || (state_q == ST_PAUSED));

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else if (!load_ok) begin
            unique case (state_q)
                ST_IDLE:   if (bus.start_stop) state_d = ST_RUN;
                ST_RUN: begin
                    // Reaching the ceiling wins over a coincident pause so DONE is never skipped.
                    if (tick && saturate)     state_d = ST_DONE;
                    else if (bus.start_stop)  state_d = ST_PAUSED;
                end
                ST_PAUSED: if (bus.start_stop) state_d = ST_RUN;
                ST_DONE:   state_d = ST_DONE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Prescaler only advances while staying in RUN; any entry or exit restarts it from zero.
    always_comb begin
        presc_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    always_comb begin
        carry_acc = tick && !saturate;
        digit_en  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_en[i] = carry_acc;
            carry_acc   = carry_acc && carry[i];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clock      (clock),
            .reset_n    (reset_n),
            .clear      (bus.clear),
            .load       (load_ok),
            .load_digit (bus.load_value[NIBBLE_W*g +: NIBBLE_W]),
            .enable     (digit_en[g]),
            .digit      (digits[NIBBLE_W*g +: NIBBLE_W]),
            .carry_out  (carry[g])
        );
    end

    assign bus.running  = running_q;
    assign bus.tick     = tick;
    assign bus.overflow = tick && all_nine;

`ifdef LAP_HOLD_EN
    logic         hold_q, hold_d;
    logic [W-1:0] disp_q, disp_d;

    always_comb begin
        hold_d = hold_q;
        disp_d = disp_q;
        if (bus.clear || (state_d != ST_RUN)) begin
            hold_d = 1'b0;
        end else if (bus.lap && (state_q == ST_RUN)) begin
            hold_d = !hold_q;
            if (!hold_q) disp_d = digits;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= 1'b0;
            disp_q <= '0;
        end else begin
            hold_q <= hold_d;
            disp_q <= disp_d;
        end
    end

    assign bus.bcd_out = hold_q ? disp_q : digits;
`else
    assign bus.bcd_out = digits;
`endif
endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb/tb_bcd_stopwatch_ctrl.sv - directed self-checking bench, DIGITS=2 TICK_DIV=4, wrap and saturate instances
module tb_bcd_stopwatch_ctrl;
    logic clock;
    logic reset_n;
    int   tests;
    int   fails;
    int   ticks;
    int   bad;

    bcd_stopwatch_ctrl_if #(.DIGITS(2)) b0 ();
    bcd_stopwatch_ctrl_if #(.DIGITS(2)) b1 ();

    bcd_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(4), .STOP_AT_MAX(0)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b0)
    );

    bcd_stopwatch_ctrl #(.DIGITS(2), .TICK_DIV(4), .STOP_AT_MAX(1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        b0.start_stop = 0; b0.clear = 0; b0.load_en = 0; b0.load_value = '0;
        b1.start_stop = 0; b1.clear = 0; b1.load_en = 0; b1.load_value = '0;
`ifdef LAP_HOLD_EN
        b0.lap = 0;
        b1.lap = 0;
`endif
        #22;
        chk("rst_bcd", b0.bcd_out, 8'h00);
        chk("rst_running", b0.running, 0);
        chk("rst_tick", b0.tick, 0);
        chk("rst_overflow", b0.overflow, 0);
        reset_n = 1'b1;
        cyc(1);

        // Free run from zero: ten ticks in forty cycles, first update five edges after the pulse.
        b0.start_stop = 1; cyc(1); b0.start_stop = 0;
        chk("run_running", b0.running, 1);
        chk("run_tick_first_cycle", b0.tick, 0);
        ticks = 0;
        bad = 0;
        for (int i = 1; i <= 39; i++) begin
            cyc(1);
            if (b0.tick === 1'b1) ticks++;
            if (b0.tick !== (((i % 4) == 3) ? 1'b1 : 1'b0)) bad++;
            if (i == 3) chk("run_before_update", b0.bcd_out, 8'h00);
            if (i == 4) chk("run_first_update", b0.bcd_out, 8'h01);
        end
        chk("run_tick_count", ticks, 10);
        chk("run_tick_period", bad, 0);
        chk("run_bcd_09", b0.bcd_out, 8'h09);
        cyc(1);
        chk("run_carry_10", b0.bcd_out, 8'h10);

        // Wrap through all-9s.
        b0.clear = 1; cyc(1); b0.clear = 0;
        chk("clr_bcd", b0.bcd_out, 8'h00);
        chk("clr_running", b0.running, 0);
        b0.load_en = 1; b0.load_value = 8'h98; cyc(1); b0.load_en = 0;
        chk("load_98", b0.bcd_out, 8'h98);
        b0.start_stop = 1; cyc(1); b0.start_stop = 0;
        cyc(3);
        chk("wrap_tick1", b0.tick, 1);
        chk("wrap_ovf_early", b0.overflow, 0);
        cyc(1);
        chk("wrap_99", b0.bcd_out, 8'h99);
        cyc(3);
        chk("wrap_tick2", b0.tick, 1);
        chk("wrap_ovf", b0.overflow, 1);
        cyc(1);
        chk("wrap_00", b0.bcd_out, 8'h00);
        chk("wrap_ovf_gone", b0.overflow, 0);
        chk("wrap_still_running", b0.running, 1);

        // Pause two cycles into a tick, resume: full TICK_DIV before the next tick.
        cyc(2);
        b0.start_stop = 1; cyc(1); b0.start_stop = 0;
        chk("pause_running", b0.running, 0);
        cyc(10);
        chk("pause_tick", b0.tick, 0);
        chk("pause_bcd", b0.bcd_out, 8'h00);
        b0.start_stop = 1; cyc(1); b0.start_stop = 0;
        chk("resume_running", b0.running, 1);
        cyc(2);
        chk("resume_no_early_tick", b0.tick, 0);
        cyc(1);
        chk("resume_tick", b0.tick, 1);
        cyc(1);
        chk("resume_bcd", b0.bcd_out, 8'h01);

        // clear + load_en + start_stop together in PAUSED: clear wins, start dropped.
        b0.start_stop = 1; cyc(1); b0.start_stop = 0;
        b0.clear = 1; b0.load_en = 1; b0.load_value = 8'h77; b0.start_stop = 1;
        cyc(1);
        b0.clear = 0; b0.load_en = 0; b0.start_stop = 0;
        chk("prio_bcd", b0.bcd_out, 8'h00);
        chk("prio_running", b0.running, 0);
        cyc(2);
        chk("prio_still_idle", b0.running, 0);
        b0.start_stop = 1; cyc(1); b0.start_stop = 0;
        b0.load_en = 1; b0.load_value = 8'h55; cyc(1); b0.load_en = 0;
        chk("load_in_run_ignored", b0.bcd_out, 8'h00);
        b0.start_stop = 1; cyc(1); b0.start_stop = 0;
        chk("pause2_running", b0.running, 0);
        b0.load_en = 1; b0.load_value = 8'hA3; cyc(1); b0.load_en = 0;
        chk("load_sanitise", b0.bcd_out, 8'h03);

`ifdef LAP_HOLD_EN
        b0.start_stop = 1; cyc(1); b0.start_stop = 0;
        b0.lap = 1; cyc(1); b0.lap = 0;
        cyc(11);
        chk("lap_frozen", b0.bcd_out, 8'h03);
        b0.lap = 1; cyc(1); b0.lap = 0;
        chk("lap_released", b0.bcd_out, 8'h06);
`endif

        // Saturating instance: stop at 99, DONE ignores start/load, clear exits.
        b1.load_en = 1; b1.load_value = 8'h99; cyc(1); b1.load_en = 0;
        chk("sat_load", b1.bcd_out, 8'h99);
        b1.start_stop = 1; cyc(1); b1.start_stop = 0;
        cyc(3);
        chk("sat_tick", b1.tick, 1);
        chk("sat_ovf", b1.overflow, 1);
        cyc(1);
        chk("sat_hold", b1.bcd_out, 8'h99);
        chk("sat_done_running", b1.running, 0);
        b1.start_stop = 1; cyc(1); b1.start_stop = 0;
        chk("sat_start_ignored", b1.running, 0);
        cyc(4);
        chk("sat_no_tick", b1.tick, 0);
        b1.load_en = 1; b1.load_value = 8'h11; cyc(1); b1.load_en = 0;
        chk("sat_load_ignored", b1.bcd_out, 8'h99);
        b1.clear = 1; cyc(1); b1.clear = 0;
        chk("sat_clear_bcd", b1.bcd_out, 8'h00);
        b1.start_stop = 1; cyc(1); b1.start_stop = 0;
        chk("sat_idle_restart", b1.running, 1);

        // Asynchronous reset mid-run.
        b0.start_stop = 1; cyc(1); b0.start_stop = 0;
        cyc(2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_bcd", b0.bcd_out, 8'h00);
        chk("arst_running", b0.running, 0);
        chk("arst_running_sat", b1.running, 0);
        #10 reset_n = 1'b1;
        cyc(2);
        chk("arst_idle", b0.running, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
